ahb_accel_ctrl: RTL and testbench

AHB_ACCEL_CTRL -- requirements
Module: ahb_accel_ctrl

---
 rtl/ahb_accel_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_ahb_accel_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_accel_ctrl.sv
// ahb_accel_ctrl -- AHB-Lite slave that controls a single accelerator.
//
// Registers (word index haddr[4:2]):
//   0 CTRL    W: bit0 START, bit1 IRQ_EN, bit2 ABORT   R: bit1 IRQ_EN
//   1 STATUS  R: bit0 BUSY, bit1 DONE, bit2 TOUT      W1C: bits 1,2
//   2 WT_PTR  R/W weight word index
//   3 WT_DATA W   weight word, streams out on wt_* and bumps WT_PTR
//   4 RESULT  R   last accelerator result
//   5 CYCLES  R   cycles spent in the last/current run (saturating)
//
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   hsel/haddr/htrans/hwrite/hsize    AHB address phase
//   hready_in, hwdata                 bus HREADY, write data (data phase)
//   hrdata/hready/hresp               slave response
//   acc_start, acc_done, acc_result   accelerator handshake
//   wt_we/wt_addr/wt_wdata            weight-memory write port
//   irq                               level interrupt
module ahb_accel_ctrl #(
    parameter int WT_AW   = 12,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             hsel,
    input  logic [7:0]       haddr,
    input  logic [1:0]       htrans,
    input  logic             hwrite,
    input  logic [2:0]       hsize,
    input  logic             hready_in,
    input  logic [31:0]      hwdata,
    output logic [31:0]      hrdata,
    output logic             hready,
    output logic             hresp,
    output logic             acc_start,
    input  logic             acc_done,
    input  logic [31:0]      acc_result,
    output logic             wt_we,
    output logic [WT_AW-1:0] wt_addr,
    output logic [31:0]      wt_wdata,
    output logic             irq
);

    localparam logic [2:0] ADDR_CTRL    = 3'd0;
    localparam logic [2:0] ADDR_STATUS  = 3'd1;
    localparam logic [2:0] ADDR_WT_PTR  = 3'd2;
    localparam logic [2:0] ADDR_WT_DATA = 3'd3;
    localparam logic [2:0] ADDR_RESULT  = 3'd4;
    localparam logic [2:0] ADDR_CYCLES  = 3'd5;

    typedef enum logic {ST_IDLE, ST_RUN} state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic             r_dp_valid;
    logic             r_dp_write;
    logic [2:0]       r_dp_idx;
    logic [2:0]       r_dp_size;
    logic             r_err2;
    logic             r_irq_en;
    logic             r_done;
    logic             r_tout;
    logic [WT_AW-1:0] r_wt_ptr;
    logic [31:0]      r_result;
    logic [31:0]      r_cycles;

    logic w_accept, w_busy, w_bad, w_ok, w_wr, w_rd;
    logic w_start_run, w_abort, w_w1c, w_timeout, w_done_evt, w_wt_wr;
    logic w_unused;

    // Address-phase bits that never influence behaviour.
    assign w_unused = ^{haddr[7:5], haddr[1:0], htrans[0]};

    assign w_accept = hsel & htrans[1] & hready_in;
    assign w_busy   = (r_state == ST_RUN);

    // An erroring transfer is judged once, in its first data cycle; the held
    // data-phase registers are ignored during the second ERROR cycle.
    assign w_bad = r_dp_valid & ~r_err2 &
                   ((r_dp_size != 3'b010) |
                    (r_dp_write & w_busy &
                     ((r_dp_idx == ADDR_WT_PTR) | (r_dp_idx == ADDR_WT_DATA))));
    assign w_ok  = r_dp_valid & ~r_err2 & ~w_bad;
    assign w_wr  = w_ok & r_dp_write;
    assign w_rd  = w_ok & ~r_dp_write;

    assign w_start_run = w_wr & (r_dp_idx == ADDR_CTRL) & hwdata[0] & ~w_busy;
    assign w_abort     = w_wr & (r_dp_idx == ADDR_CTRL) & hwdata[2];
    assign w_w1c       = w_wr & (r_dp_idx == ADDR_STATUS);
    assign w_wt_wr     = w_wr & (r_dp_idx == ADDR_WT_DATA);
    assign w_done_evt  = w_busy & acc_done;
    assign w_timeout   = w_busy & (r_cycles == 32'(TIMEOUT - 1));

    // Address phase capture; held while the bus is stalled.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_idx   <= 3'd0;
            r_dp_size  <= 3'd0;
            r_err2     <= 1'b0;
        end else begin
            r_err2 <= w_bad;
            if (hready_in) begin
                r_dp_valid <= w_accept;
                if (w_accept) begin
                    r_dp_write <= hwrite;
                    r_dp_idx   <= haddr[4:2];
                    r_dp_size  <= hsize;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: defaults first so no path through always_comb leaves a variable unassigned (no latches).
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start_run) w_state_next = ST_RUN;
            ST_RUN:  if (acc_done || w_timeout || w_abort) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_en <= 1'b0;
            r_done   <= 1'b0;
            r_tout   <= 1'b0;
            r_wt_ptr <= '0;
            r_result <= '0;
            r_cycles <= '0;
        end else begin
            if (w_wr && (r_dp_idx == ADDR_CTRL)) r_irq_en <= hwdata[1];

            if (w_wr && (r_dp_idx == ADDR_WT_PTR)) r_wt_ptr <= hwdata[WT_AW-1:0];
            else if (w_wt_wr)                      r_wt_ptr <= r_wt_ptr + 1'b1;

            if (w_start_run) begin
                r_cycles <= '0;
                r_done   <= 1'b0;
                r_tout   <= 1'b0;
            end else begin
                if (w_busy && (r_cycles != '1)) r_cycles <= r_cycles + 1'b1;

                // Hardware set beats a coincident W1C.
                if (w_done_evt) begin
                    r_done   <= 1'b1;
                    r_result <= acc_result;
                end else if (w_w1c && hwdata[1]) begin
                    r_done <= 1'b0;
                end

                if (w_timeout && !acc_done)  r_tout <= 1'b1;
                else if (w_w1c && hwdata[2]) r_tout <= 1'b0;
            end
        end
    end

    always_comb begin
        hrdata = '0;
        if (w_rd) begin
            case (r_dp_idx)
                ADDR_CTRL:   hrdata[1]         = r_irq_en;
                ADDR_STATUS: hrdata[2:0]       = {r_tout, r_done, w_busy};
                ADDR_WT_PTR: hrdata[WT_AW-1:0] = r_wt_ptr;
                ADDR_RESULT: hrdata            = r_result;
                ADDR_CYCLES: hrdata            = r_cycles;
                default:     hrdata            = '0;
            endcase
        end
    end

    assign hready    = ~w_bad;
    assign hresp     = w_bad | r_err2;
    assign acc_start = w_busy;
    assign wt_we     = w_wt_wr;
    assign wt_addr   = r_wt_ptr;
    assign wt_wdata  = hwdata;
    assign irq       = r_irq_en & (r_done | r_tout);

endmodule

// File: tb/tb_ahb_accel_ctrl.sv
// Directed testbench for ahb_accel_ctrl (TIMEOUT overridden to 16).
module tb_ahb_accel_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        hsel;
    logic [7:0]  haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic        hready_in;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;
    logic        acc_start;
    logic        acc_done;
    logic [31:0] acc_result;
    logic        wt_we;
    logic [11:0] wt_addr;
    logic [31:0] wt_wdata;
    logic        irq;

    int total = 0;
    int bad   = 0;
    int we_count = 0;

    logic        last_we;
    logic [11:0] last_waddr;
    logic [31:0] last_wdata;

    always #5 clk = ~clk;

    // Single slave on the bus: its own HREADY is the bus HREADY.
    assign hready_in = hready;

    ahb_accel_ctrl #(.WT_AW(12), .TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .hready_in(hready_in), .hwdata(hwdata),
        .hrdata(hrdata), .hready(hready), .hresp(hresp),
        .acc_start(acc_start), .acc_done(acc_done), .acc_result(acc_result),
        .wt_we(wt_we), .wt_addr(wt_addr), .wt_wdata(wt_wdata), .irq(irq)
    );

    always @(negedge clk) if (wt_we === 1'b1) we_count++;

    // One AHB transfer: address cycle, data cycle, plus a second cycle on ERROR.
    // resp: 0 = OKAY, 1 = well-formed two-cycle ERROR, 2 = anything else.
    task automatic xfer(input logic wr, input logic [7:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, input logic done_pulse,
                        output logic [31:0] rdata, output int resp);
        @(posedge clk); #1;
        acc_done = 1'b0;
        hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = addr; hsize = size;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = wdata; acc_done = done_pulse;
        @(negedge clk);
        rdata = hrdata;
        last_we = wt_we; last_waddr = wt_addr; last_wdata = wt_wdata;
        if (hready === 1'b1 && hresp === 1'b0) begin
            resp = 0;
        end else if (hready === 1'b0 && hresp === 1'b1) begin
            @(posedge clk); #1;
            acc_done = 1'b0;
            @(negedge clk);
            if (wt_we === 1'b1) last_we = 1'b1;
            resp = (hready === 1'b1 && hresp === 1'b1) ? 1 : 2;
        end else begin
            resp = 2;
        end
    endtask

    task automatic wr32(input logic [7:0] addr, input logic [31:0] data, output int resp);
        logic [31:0] d;
        xfer(1'b1, addr, 3'b010, data, 1'b0, d, resp);
    endtask

    task automatic rd32(input logic [7:0] addr, output logic [31:0] data, output int resp);
        xfer(1'b0, addr, 3'b010, 32'h0, 1'b0, data, resp);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        int r;
        total++;
        if ({hready, hresp, hrdata, acc_start, wt_we, irq} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_outputs: got hready=%b hresp=%b hrdata=%h start=%b we=%b irq=%b",
                     hready, hresp, hrdata, acc_start, wt_we, irq);
        end
        @(negedge clk); reset_n = 1'b1;
        rd32(8'h04, d, r);
        total++;
        if (d !== 32'h0 || r !== 0) begin bad++; $display("FAIL reset_status: got %h resp %0d want 0", d, r); end
        rd32(8'h14, d, r);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL reset_cycles: got %h want 0", d); end
    endtask

    task automatic test_regmap;
        logic [31:0] d;
        int r;
        wr32(8'h18, 32'hFFFF_FFFF, r);
        total++;
        if (r !== 0) begin bad++; $display("FAIL unmapped_write_resp: got %0d want 0", r); end
        rd32(8'h18, d, r);
        total++;
        if (d !== 32'h0 || r !== 0) begin bad++; $display("FAIL unmapped_read: got %h resp %0d want 0", d, r); end
        wr32(8'h00, 32'h2, r);
        rd32(8'h00, d, r);
        total++;
        if (d !== 32'h2) begin bad++; $display("FAIL ctrl_readback: got %h want 2", d); end
        rd32(8'h04, d, r);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL status_no_start: got %h want 0", d); end
    endtask

    task automatic test_weight_load;
        logic [31:0] d;
        int r;
        int base;
        logic [11:0] exp_idx [3] = '{12'hFFE, 12'hFFF, 12'h000};
        logic [31:0] exp_dat [3] = '{32'hA, 32'hB, 32'hC};
        wr32(8'h08, 32'hFFE, r);
        base = we_count;
        for (int i = 0; i < 3; i++) begin
            wr32(8'h0C, exp_dat[i], r);
            total++;
            if (last_we !== 1'b1 || last_waddr !== exp_idx[i] || last_wdata !== exp_dat[i] || r !== 0) begin
                bad++;
                $display("FAIL wt_write%0d: got we=%b idx=%h data=%h resp=%0d want 1 %h %h 0",
                         i, last_we, last_waddr, last_wdata, r, exp_idx[i], exp_dat[i]);
            end
        end
        rd32(8'h08, d, r);
        total++;
        if (d !== 32'h1) begin bad++; $display("FAIL wt_ptr_wrap: got %h want 1", d); end
        total++;
        if (we_count - base !== 3) begin bad++; $display("FAIL wt_we_pulses: got %0d want 3", we_count - base); end
    endtask

    task automatic test_normal_run;
        logic [31:0] d;
        int r;
        int cnt = 0;
        wr32(8'h00, 32'h3, r);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i == 9) begin acc_done = 1'b1; acc_result = 32'h1234; end
            @(negedge clk);
            if (acc_start === 1'b1) cnt++;
        end
        @(posedge clk); #1; acc_done = 1'b0;
        @(negedge clk);
        total++;
        if (cnt !== 10 || acc_start !== 1'b0) begin
            bad++; $display("FAIL run_start_len: got %0d cycles, after=%b want 10, 0", cnt, acc_start);
        end
        rd32(8'h04, d, r);
        total++;
        if (d !== 32'h2) begin bad++; $display("FAIL run_status: got %h want 2", d); end
        rd32(8'h10, d, r);
        total++;
        if (d !== 32'h1234) begin bad++; $display("FAIL run_result: got %h want 1234", d); end
        rd32(8'h14, d, r);
        total++;
        if (d !== 32'd10) begin bad++; $display("FAIL run_cycles: got %0d want 10", d); end
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL run_irq: got %b want 1", irq); end
        wr32(8'h04, 32'h2, r);
        @(negedge clk);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL w1c_irq: got %b want 0", irq); end
        rd32(8'h04, d, r);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL w1c_status: got %h want 0", d); end
    endtask

    task automatic test_timeout;
        logic [31:0] d;
        int r;
        int cnt = 0;
        bit seen_low = 1'b0;
        wr32(8'h00, 32'h1, r);
        for (int i = 0; i < 40 && !seen_low; i++) begin
            @(posedge clk); @(negedge clk);
            if (acc_start === 1'b1) cnt++;
            else seen_low = 1'b1;
        end
        total++;
        if (!seen_low || cnt !== 16) begin
            bad++; $display("FAIL timeout_len: got %0d cycles (ended=%b) want 16", cnt, seen_low);
        end
        rd32(8'h04, d, r);
        total++;
        if (d !== 32'h4) begin bad++; $display("FAIL timeout_status: got %h want 4", d); end
        rd32(8'h10, d, r);
        total++;
        if (d !== 32'h1234) begin bad++; $display("FAIL timeout_result: got %h want 1234", d); end
        rd32(8'h14, d, r);
        total++;
        if (d !== 32'd16) begin bad++; $display("FAIL timeout_cycles: got %0d want 16", d); end
    endtask

    task automatic test_busy_protect;
        logic [31:0] d;
        int r;
        int base;
        wr32(8'h00, 32'h1, r);
        base = we_count;
        wr32(8'h0C, 32'hDEAD, r);
        total++;
        if (r !== 1 || last_we !== 1'b0 || we_count !== base) begin
            bad++; $display("FAIL busy_wt_data: got resp=%0d we=%b want 1, 0", r, last_we);
        end
        xfer(1'b0, 8'h04, 3'b000, 32'h0, 1'b0, d, r);
        total++;
        if (r !== 1) begin bad++; $display("FAIL hsize_err: got resp %0d want 1", r); end
        wr32(8'h00, 32'h1, r);
        total++;
        if (r !== 0) begin bad++; $display("FAIL busy_start_resp: got %0d want 0", r); end
        rd32(8'h14, d, r);
        total++;
        if (d !== 32'd9) begin bad++; $display("FAIL busy_cycles: got %0d want 9", d); end
        wr32(8'h00, 32'h4, r);
        rd32(8'h04, d, r);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL abort_status: got %h want 0", d); end
    endtask

    task automatic test_collisions;
        logic [31:0] d;
        int r;
        wr32(8'h00, 32'h1, r);
        acc_result = 32'h5555_AAAA;
        xfer(1'b1, 8'h00, 3'b010, 32'h4, 1'b1, d, r);
        rd32(8'h04, d, r);
        total++;
        if (d !== 32'h2) begin bad++; $display("FAIL abort_vs_done_status: got %h want 2", d); end
        rd32(8'h10, d, r);
        total++;
        if (d !== 32'h5555_AAAA) begin bad++; $display("FAIL abort_vs_done_result: got %h want 5555aaaa", d); end
        wr32(8'h00, 32'h1, r);
        acc_result = 32'h77;
        xfer(1'b1, 8'h04, 3'b010, 32'h2, 1'b1, d, r);
        rd32(8'h04, d, r);
        total++;
        if (d !== 32'h2) begin bad++; $display("FAIL w1c_vs_done_status: got %h want 2", d); end
        rd32(8'h10, d, r);
        total++;
        if (d !== 32'h77) begin bad++; $display("FAIL w1c_vs_done_result: got %h want 77", d); end
    endtask

    task automatic test_reset_midrun;
        logic [31:0] d;
        int r;
        wr32(8'h00, 32'h3, r);
        repeat (5) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({acc_start, hready, hresp, hrdata, wt_we, irq} !== {1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL midrun_reset_outputs: got start=%b hready=%b hresp=%b hrdata=%h we=%b irq=%b",
                     acc_start, hready, hresp, hrdata, wt_we, irq);
        end
        @(negedge clk); @(negedge clk); reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rd32(8'(i * 4), d, r);
            total++;
            if (d !== 32'h0 || r !== 0) begin
                bad++; $display("FAIL midrun_reg%0d: got %h resp %0d want 0", i, d, r);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        hsel = 1'b0; haddr = 8'h0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'b010;
        hwdata = 32'h0; acc_done = 1'b0; acc_result = 32'h0;
        #12;
        test_reset;
        test_regmap;
        test_weight_load;
        test_normal_run;
        test_timeout;
        test_busy_protect;
        test_collisions;
        test_reset_midrun;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
